// File: rtl/ifu_pkg.sv
// Shared parameters and types for the instruction-fetch memory responder.
// The line-store geometry and the FSM state encoding live here.
package ifu_pkg;

    localparam int TAG_WIDTH     = 28;
    localparam int LINE_WIDTH    = 128;
    localparam int MEM_LATENCY   = 3;
    localparam int MEM_IDX_WIDTH = 8;
    localparam int MEM_LINES     = 256;
    localparam int CNT_WIDTH     = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } t_ifu_mem_state;

    // Tags beyond the line store's index range have to return an error response.
    function automatic logic tag_in_range(input logic [TAG_WIDTH-1:0] tag);
        return (tag[TAG_WIDTH-1:MEM_IDX_WIDTH] == {(TAG_WIDTH-MEM_IDX_WIDTH){1'b0}});
    endfunction

endpackage

// File: rtl/ifu_mem_line_store.sv
// Backing line store: one synchronous write port and one combinational read port.
// The array has no reset so a preloaded image survives Rst.
module ifu_mem_line_store
    import ifu_pkg::*;
(
    input  logic                     Clock,
    input  logic                     wr_en,
    input  logic [MEM_IDX_WIDTH-1:0] wr_idx,
    input  logic [LINE_WIDTH-1:0]    wr_line,
    input  logic [MEM_IDX_WIDTH-1:0] rd_idx,
    output logic [LINE_WIDTH-1:0]    rd_line
);

    logic [LINE_WIDTH-1:0] mem_r [MEM_LINES];

    // Loader write; a reader registering rd_line on the same edge sees the old data.
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem_r[wr_idx] <= wr_line;
        end
    end

    assign rd_line = mem_r[rd_idx];

endmodule

// File: rtl/ifu_mem_rsp.sv
// Fixed-latency memory responder for instruction-cache line misses.
// Tracks one outstanding tag, aborts when the request changes or drops, and returns a one-cycle response.
module ifu_mem_rsp
    import ifu_pkg::*;
(
    input  logic                     Clock,
    input  logic                     Rst,
    input  logic [TAG_WIDTH-1:0]     mem_reqTagIn,
    input  logic                     mem_reqTagValidIn,
    input  logic                     ld_wrEnIn,
    input  logic [MEM_IDX_WIDTH-1:0] ld_wrIdxIn,
    input  logic [LINE_WIDTH-1:0]    ld_wrLineIn,
    output logic [TAG_WIDTH-1:0]     mem_rspTagOut,
    output logic [LINE_WIDTH-1:0]    mem_rspInsLineOut,
    output logic                     mem_rspInsLineValidOut,
    output logic                     mem_rspErrOut,
    output logic                     busyOut,
    output logic [7:0]               abortCntOut
);

    t_ifu_mem_state        state_r;
    logic [CNT_WIDTH-1:0]  cnt_r;
    logic [TAG_WIDTH-1:0]  req_tag_r;
    logic [LINE_WIDTH-1:0] rd_line_s;
    logic                  req_match_s;

    ifu_mem_line_store u_line_store (
        .Clock   (Clock),
        .wr_en   (ld_wrEnIn),
        .wr_idx  (ld_wrIdxIn),
        .wr_line (ld_wrLineIn),
        .rd_idx  (req_tag_r[MEM_IDX_WIDTH-1:0]),
        .rd_line (rd_line_s)
    );

    assign req_match_s = mem_reqTagValidIn && (mem_reqTagIn == req_tag_r);

    // Fetch FSM with latency counter, abort counter and registered response outputs.
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            state_r                <= IDLE;
            cnt_r                  <= {CNT_WIDTH{1'b0}};
            req_tag_r              <= {TAG_WIDTH{1'b0}};
            mem_rspTagOut          <= {TAG_WIDTH{1'b0}};
            mem_rspInsLineOut      <= {LINE_WIDTH{1'b0}};
            mem_rspInsLineValidOut <= 1'b0;
            mem_rspErrOut          <= 1'b0;
            busyOut                <= 1'b0;
            abortCntOut            <= 8'd0;
        end else begin
            mem_rspInsLineValidOut <= 1'b0;
            mem_rspErrOut          <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (mem_reqTagValidIn) begin
                        req_tag_r <= mem_reqTagIn;
                        cnt_r     <= CNT_WIDTH'(MEM_LATENCY - 1);
                        state_r   <= WAIT;
                        busyOut   <= 1'b1;
                    end else begin
                        state_r   <= IDLE;
                        busyOut   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (!req_match_s) begin
                        state_r <= IDLE;
                        busyOut <= 1'b0;
                        if (abortCntOut != 8'hFF) begin
                            abortCntOut <= abortCntOut + 8'd1;
                        end
                    end else if (cnt_r == {CNT_WIDTH{1'b0}}) begin
                        state_r                <= RESP;
                        busyOut                <= 1'b1;
                        mem_rspTagOut          <= req_tag_r;
                        mem_rspInsLineValidOut <= 1'b1;
                        // Out-of-range tags return a zero line flagged as an error.
                        if (tag_in_range(req_tag_r)) begin
                            mem_rspInsLineOut <= rd_line_s;
                            mem_rspErrOut     <= 1'b0;
                        end else begin
                            mem_rspInsLineOut <= {LINE_WIDTH{1'b0}};
                            mem_rspErrOut     <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_WIDTH'(1);
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                    busyOut <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busyOut <= 1'b0;
                end
            endcase
        end
    end

endmodule
